// File: rtl/bfly_stage00.sv
// ---------------------------------------------------------------------------
// bfly_stage00 -- first radix-2 butterfly stage of a 16-lane streaming FFT.
//
// A block is two half-blocks of HALF_BLK beats, NLANE samples per beat.
// FILL half-block : input beats are sign-extended and parked in the buffer.
// CALC half-block : each input beat meets the parked beat at the same index;
//                   the sum goes straight out (mux_sel=0), the difference is
//                   written back into the buffer.
// The parked differences are emitted (mux_sel=1) during the next FILL
// half-block, one slot ahead of being overwritten, or drained by flush when
// no further input arrives.
//
// Optional feature (macro BFLY00_SCALE_EN): sum and difference are
// arithmetically shifted right by one (floor) before being registered or
// stored. Without the macro results are full precision and unscaled.
//
// Ports
//   clk           clock, rising edge
//   rstn          asynchronous active-low reset
//   din_valid     input lanes valid this cycle (wins over flush)
//   flush         drain pending differences without new input
//   din_R/din_Q   NLANE x signed [DATA_WIDTH-2:0] real/imag input lanes
//   dout_valid    one output beat valid
//   mux_sel       0 = add beat, 1 = sub beat
//   dout_R_add00/dout_Q_add00  NLANE x signed [DATA_WIDTH-1:0] butterfly sum
//   dout_R_sub00/dout_Q_sub00  NLANE x signed [DATA_WIDTH-1:0] butterfly diff
//   sub_pending   buffer holds differences not yet emitted
// ---------------------------------------------------------------------------
module bfly_stage00 #(
  parameter int DATA_WIDTH = 10,
  parameter int NLANE      = 16,
  parameter int HALF_BLK   = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         din_valid,
  input  logic                         flush,
  input  logic signed [DATA_WIDTH-2:0] din_R        [0:NLANE-1],
  input  logic signed [DATA_WIDTH-2:0] din_Q        [0:NLANE-1],
  output logic                         dout_valid,
  output logic                         mux_sel,
  output logic signed [DATA_WIDTH-1:0] dout_R_add00 [0:NLANE-1],
  output logic signed [DATA_WIDTH-1:0] dout_Q_add00 [0:NLANE-1],
  output logic signed [DATA_WIDTH-1:0] dout_R_sub00 [0:NLANE-1],
  output logic signed [DATA_WIDTH-1:0] dout_Q_sub00 [0:NLANE-1],
  output logic                         sub_pending
);

  localparam int CNT_W = (HALF_BLK > 1) ? $clog2(HALF_BLK) : 1;
  localparam int ROW_W = NLANE * DATA_WIDTH;

  localparam logic [0:0] PH_FILL = 1'b0;
  localparam logic [0:0] PH_CALC = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_BLK - 1);

  typedef logic signed [DATA_WIDTH-1:0] samp_t;

  // Sign-extend an input lane to output width.
  function automatic samp_t sext(input logic signed [DATA_WIDTH-2:0] x);
    return {x[DATA_WIDTH-2], x};
  endfunction

  // Optional halving of butterfly results; >>> on a signed value floors.
  function automatic samp_t scale(input samp_t x);
`ifdef BFLY00_SCALE_EN
    return x >>> 1;
`else
    return x;
`endif
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [0:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             subp_q,  subp_d;
  logic             vld_q,   vld_d;
  logic             mux_q,   mux_d;

  samp_t add_R_q [0:NLANE-1];
  samp_t add_R_d [0:NLANE-1];
  samp_t add_Q_q [0:NLANE-1];
  samp_t add_Q_d [0:NLANE-1];
  samp_t sub_R_q [0:NLANE-1];
  samp_t sub_R_d [0:NLANE-1];
  samp_t sub_Q_q [0:NLANE-1];
  samp_t sub_Q_d [0:NLANE-1];

  // Buffer rows are packed so one row is written by a single assignment.
  logic [ROW_W-1:0] buf_R [0:HALF_BLK-1];
  logic [ROW_W-1:0] buf_Q [0:HALF_BLK-1];

  logic [ROW_W-1:0] rd_row_R, rd_row_Q;
  logic [ROW_W-1:0] wr_row_R, wr_row_Q;
  logic             buf_we;
  logic             buf_sel_dif;

  samp_t rd_R  [0:NLANE-1];
  samp_t rd_Q  [0:NLANE-1];
  samp_t in_R  [0:NLANE-1];
  samp_t in_Q  [0:NLANE-1];
  samp_t sum_R [0:NLANE-1];
  samp_t sum_Q [0:NLANE-1];
  samp_t dif_R [0:NLANE-1];
  samp_t dif_Q [0:NLANE-1];

  logic last_beat;
  logic fill_beat;
  logic calc_beat;
  logic flush_beat;

  // -------------------------------------------------------------------------
  // Per-lane datapath: buffer read, extension, sum and difference
  // -------------------------------------------------------------------------
  assign rd_row_R = buf_R[cnt_q];
  assign rd_row_Q = buf_Q[cnt_q];

  always_comb begin
    for (int l = 0; l < NLANE; l++) begin
      rd_R[l]  = samp_t'(rd_row_R[l*DATA_WIDTH +: DATA_WIDTH]);
      rd_Q[l]  = samp_t'(rd_row_Q[l*DATA_WIDTH +: DATA_WIDTH]);
      in_R[l]  = sext(din_R[l]);
      in_Q[l]  = sext(din_Q[l]);
      // Operands span DATA_WIDTH-1 bits, so DATA_WIDTH holds sum and diff.
      sum_R[l] = scale(samp_t'(rd_R[l] + in_R[l]));
      sum_Q[l] = scale(samp_t'(rd_Q[l] + in_Q[l]));
      dif_R[l] = scale(samp_t'(rd_R[l] - in_R[l]));
      dif_Q[l] = scale(samp_t'(rd_Q[l] - in_Q[l]));
    end
  end

  // -------------------------------------------------------------------------
  // Beat classification
  // -------------------------------------------------------------------------
  assign last_beat  = (cnt_q == CNT_LAST);
  assign calc_beat  = din_valid && (phase_q == PH_CALC);
  assign fill_beat  = din_valid && (phase_q == PH_FILL);
  // flush only counts when there is something to drain and no input beat.
  assign flush_beat = !din_valid && flush && (phase_q == PH_FILL) && subp_q;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    subp_d      = subp_q;
    vld_d       = 1'b0;
    mux_d       = mux_q;
    add_R_d     = add_R_q;
    add_Q_d     = add_Q_q;
    sub_R_d     = sub_R_q;
    sub_Q_d     = sub_Q_q;
    buf_we      = 1'b0;
    buf_sel_dif = 1'b0;

    if (calc_beat) begin
      vld_d       = 1'b1;
      mux_d       = 1'b0;
      add_R_d     = sum_R;
      add_Q_d     = sum_Q;
      buf_we      = 1'b1;
      buf_sel_dif = 1'b1;
      if (last_beat) begin
        cnt_d   = '0;
        phase_d = PH_FILL;
        subp_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (fill_beat || flush_beat) begin
      // The old difference is read out in the same cycle the slot is
      // overwritten, so emission always stays one step ahead of the write.
      if (subp_q) begin
        vld_d   = 1'b1;
        mux_d   = 1'b1;
        sub_R_d = rd_R;
        sub_Q_d = rd_Q;
      end
      buf_we = fill_beat;
      if (last_beat) begin
        cnt_d  = '0;
        subp_d = 1'b0;
        // A drained half-block leaves nothing stored, so stay in FILL.
        if (fill_beat) begin
          phase_d = PH_CALC;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Row to be written: either the extended input or the new difference.
  always_comb begin
    wr_row_R = '0;
    wr_row_Q = '0;
    for (int l = 0; l < NLANE; l++) begin
      wr_row_R[l*DATA_WIDTH +: DATA_WIDTH] = buf_sel_dif ? dif_R[l] : in_R[l];
      wr_row_Q[l*DATA_WIDTH +: DATA_WIDTH] = buf_sel_dif ? dif_Q[l] : in_Q[l];
    end
  end

  // -------------------------------------------------------------------------
  // Registers: control and output beat (reset), buffer (no reset)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_q <= PH_FILL;
      cnt_q   <= '0;
      subp_q  <= 1'b0;
      vld_q   <= 1'b0;
      mux_q   <= 1'b0;
      add_R_q <= '{default: '0};
      add_Q_q <= '{default: '0};
      sub_R_q <= '{default: '0};
      sub_Q_q <= '{default: '0};
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      subp_q  <= subp_d;
      vld_q   <= vld_d;
      mux_q   <= mux_d;
      add_R_q <= add_R_d;
      add_Q_q <= add_Q_d;
      sub_R_q <= sub_R_d;
      sub_Q_q <= sub_Q_d;
    end
  end

  // Buffer contents are only read after being written in the same block,
  // so they need no reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_R[cnt_q] <= wr_row_R;
      buf_Q[cnt_q] <= wr_row_Q;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign dout_valid   = vld_q;
  assign mux_sel      = mux_q;
  assign sub_pending  = subp_q;
  assign dout_R_add00 = add_R_q;
  assign dout_Q_add00 = add_Q_q;
  assign dout_R_sub00 = sub_R_q;
  assign dout_Q_sub00 = sub_Q_q;

endmodule

// File: tb/tb_bfly_stage00.sv
// Testbench for bfly_stage00: directed block scenarios plus randomized
// traffic, checked every cycle against a behavioural model of the
// FILL/CALC butterfly buffer.
module tb_bfly_stage00;

  localparam int DW = 10;
  localparam int NL = 16;
  localparam int HB = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic din_valid = 1'b0;
  logic flush = 1'b0;
  logic signed [DW-2:0] din_R [0:NL-1];
  logic signed [DW-2:0] din_Q [0:NL-1];
  logic dout_valid, mux_sel, sub_pending;
  logic signed [DW-1:0] dout_R_add00 [0:NL-1];
  logic signed [DW-1:0] dout_Q_add00 [0:NL-1];
  logic signed [DW-1:0] dout_R_sub00 [0:NL-1];
  logic signed [DW-1:0] dout_Q_sub00 [0:NL-1];

  int checks = 0;
  int errors = 0;
  int n_add = 0;
  int n_sub = 0;

  bfly_stage00 #(.DATA_WIDTH(DW), .NLANE(NL), .HALF_BLK(HB)) dut (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .flush(flush),
    .din_R(din_R), .din_Q(din_Q),
    .dout_valid(dout_valid), .mux_sel(mux_sel),
    .dout_R_add00(dout_R_add00), .dout_Q_add00(dout_Q_add00),
    .dout_R_sub00(dout_R_sub00), .dout_Q_sub00(dout_Q_sub00),
    .sub_pending(sub_pending)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit m_calc, m_subp, m_vld, m_mux;
  int m_cnt;
  int mbR [HB][NL];
  int mbQ [HB][NL];
  int m_addR [NL];
  int m_addQ [NL];
  int m_subR [NL];
  int m_subQ [NL];

  function automatic int wrapv(input int x);
    int m, y;
    m = 1 << DW;
    y = x % m;
    if (y >= m / 2) y -= m;
    else if (y < -(m / 2)) y += m;
    return y;
  endfunction

  // Halving with floor, done arithmetically rather than by shifting.
  function automatic int scl(input int x);
`ifdef BFLY00_SCALE_EN
    if (x >= 0) return x / 2;
    return -((1 - x) / 2);
`else
    return x;
`endif
  endfunction

  task automatic model_reset();
    m_calc = 0; m_subp = 0; m_vld = 0; m_mux = 0; m_cnt = 0;
    for (int l = 0; l < NL; l++) begin
      m_addR[l] = 0; m_addQ[l] = 0; m_subR[l] = 0; m_subQ[l] = 0;
    end
  endtask

  task automatic model_step(input bit dv, input bit fl);
    int rin [NL];
    int qin [NL];
    for (int l = 0; l < NL; l++) begin
      rin[l] = int'(din_R[l]);
      qin[l] = int'(din_Q[l]);
    end
    m_vld = 0;
    if (dv && m_calc) begin
      for (int l = 0; l < NL; l++) begin
        m_addR[l] = scl(wrapv(mbR[m_cnt][l] + rin[l]));
        m_addQ[l] = scl(wrapv(mbQ[m_cnt][l] + qin[l]));
        mbR[m_cnt][l] = scl(wrapv(mbR[m_cnt][l] - rin[l]));
        mbQ[m_cnt][l] = scl(wrapv(mbQ[m_cnt][l] - qin[l]));
      end
      m_vld = 1; m_mux = 0;
      if (m_cnt == HB - 1) begin m_cnt = 0; m_calc = 0; m_subp = 1; end
      else m_cnt++;
    end else if (dv || (fl && !m_calc && m_subp)) begin
      if (m_subp) begin
        m_vld = 1; m_mux = 1;
        for (int l = 0; l < NL; l++) begin
          m_subR[l] = mbR[m_cnt][l];
          m_subQ[l] = mbQ[m_cnt][l];
        end
      end
      if (dv)
        for (int l = 0; l < NL; l++) begin
          mbR[m_cnt][l] = rin[l];
          mbQ[m_cnt][l] = qin[l];
        end
      if (m_cnt == HB - 1) begin
        m_cnt = 0; m_subp = 0;
        if (dv) m_calc = 1;
      end else m_cnt++;
    end
  endtask

  always @(posedge clk) if (rstn) model_step(din_valid, flush);
  always @(negedge rstn) model_reset();

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic chk_arr(input string nm, input int act [NL], input int exp [NL]);
    int bad;
    bad = -1;
    for (int l = NL - 1; l >= 0; l--) if (act[l] != exp[l]) bad = l;
    checks++;
    if (bad >= 0) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s lane %0d at %0t: got %0d expected %0d",
                 nm, bad, $time, act[bad], exp[bad]);
    end
  endtask

  function automatic void grab(output int aR [NL], output int aQ [NL],
                               output int sR [NL], output int sQ [NL]);
    for (int l = 0; l < NL; l++) begin
      aR[l] = int'(dout_R_add00[l]); aQ[l] = int'(dout_Q_add00[l]);
      sR[l] = int'(dout_R_sub00[l]); sQ[l] = int'(dout_Q_sub00[l]);
    end
  endfunction

  // Compare process: every cycle, DUT against model.
  always @(negedge clk) begin
    int aR [NL]; int aQ [NL]; int sR [NL]; int sQ [NL];
    grab(aR, aQ, sR, sQ);
    chk("dout_valid", int'(dout_valid), int'(m_vld));
    chk("mux_sel", int'(mux_sel), int'(m_mux));
    chk("sub_pending", int'(sub_pending), int'(m_subp));
    chk_arr("dout_R_add00", aR, m_addR);
    chk_arr("dout_Q_add00", aQ, m_addQ);
    chk_arr("dout_R_sub00", sR, m_subR);
    chk_arr("dout_Q_sub00", sQ, m_subQ);
    if (dout_valid) begin
      if (mux_sel) n_sub++;
      else n_add++;
    end
  end

  // Literal check: all lanes of one output array equal a constant.
  task automatic chk_lanes(input string nm, input int which, input int exp);
    int aR [NL]; int aQ [NL]; int sR [NL]; int sQ [NL];
    int e [NL];
    grab(aR, aQ, sR, sQ);
    for (int l = 0; l < NL; l++) e[l] = exp;
    case (which)
      0: chk_arr(nm, aR, e);
      1: chk_arr(nm, aQ, e);
      2: chk_arr(nm, sR, e);
      default: chk_arr(nm, sQ, e);
    endcase
  endtask

  // ---------------- stimulus ----------------
  task automatic drive(input bit dv, input bit fl, input int r, input int q,
                       input bit rnd);
    @(negedge clk);
    din_valid = dv;
    flush = fl;
    for (int l = 0; l < NL; l++) begin
      if (rnd) begin
        din_R[l] = (DW - 1)'($urandom);
        din_Q[l] = (DW - 1)'($urandom);
      end else begin
        din_R[l] = (DW - 1)'(r);
        din_Q[l] = (DW - 1)'(q);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    din_valid = 0;
    flush = 0;
    #2 rstn = 0;
    #1;
    chk("rst dout_valid", int'(dout_valid), 0);
    chk("rst mux_sel", int'(mux_sel), 0);
    chk("rst sub_pending", int'(sub_pending), 0);
    for (int w = 0; w < 4; w++) chk_lanes("rst dout", w, 0);
    @(negedge clk);
    #2 rstn = 1;
  endtask

  task automatic settle();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
  endtask

  int base;
  int exp_add_r, exp_add_q, exp_sub_r, exp_sub_q, exp_x_sub;

  initial begin
`ifdef BFLY00_SCALE_EN
    exp_add_r = 2;  exp_add_q = -1; exp_sub_r = -1; exp_sub_q = 1; exp_x_sub = 255;
`else
    exp_add_r = 4;  exp_add_q = -2; exp_sub_r = -2; exp_sub_q = 2; exp_x_sub = 511;
`endif
    model_reset();
    for (int l = 0; l < NL; l++) begin din_R[l] = '0; din_Q[l] = '0; end
    repeat (2) @(negedge clk);
    #2 rstn = 1;
    do_reset();

    // Block of ones then (3,-2): 16 add beats.
    base = n_add;
    for (int i = 0; i < HB; i++) drive(1, 0, 1, 0, 0);
    for (int i = 0; i < HB; i++) drive(1, 0, 3, -2, 0);
    settle();
    chk("add beats", n_add - base, 16);
    chk_lanes("add R", 0, exp_add_r);
    chk_lanes("add Q", 1, exp_add_q);
    chk("add mux_sel hold", int'(mux_sel), 0);
    chk("idle dout_valid", int'(dout_valid), 0);
    chk("pending after calc", int'(sub_pending), 1);

    // FILL with zeros emits the differences.
    base = n_sub;
    for (int i = 0; i < HB; i++) drive(1, 0, 0, 0, 0);
    settle();
    chk("sub beats", n_sub - base, 16);
    chk_lanes("sub R", 2, exp_sub_r);
    chk_lanes("sub Q", 3, exp_sub_q);
    chk_lanes("add R hold", 0, exp_add_r);
    chk("sub mux_sel", int'(mux_sel), 1);
    chk("pending cleared", int'(sub_pending), 0);

    // Flush drain, with ignored flushes beforehand.
    do_reset();
    base = n_add + n_sub;
    repeat (3) drive(0, 1, 0, 0, 0);
    settle();
    chk("flush ignored", n_add + n_sub - base, 0);
    for (int i = 0; i < HB; i++) drive(1, 0, 1, 0, 0);
    for (int i = 0; i < HB; i++) drive(1, 0, 3, -2, 0);
    base = n_sub;
    repeat (20) drive(0, 1, 0, 0, 0);
    settle();
    chk("flush sub beats", n_sub - base, 16);
    chk("flush dout_valid", int'(dout_valid), 0);
    chk_lanes("flush sub R", 2, exp_sub_r);

    // Extremes.
    do_reset();
    for (int i = 0; i < HB; i++) drive(1, 0, 255, 0, 0);
    for (int i = 0; i < HB; i++) drive(1, 0, -256, 0, 0);
    settle();
    chk_lanes("extreme add R", 0, -1);
    repeat (HB) drive(0, 1, 0, 0, 0);
    settle();
    chk_lanes("extreme sub R", 2, exp_x_sub);

    // Gapped input, flush asserted during gaps (ignored).
    do_reset();
    base = n_add;
    for (int i = 0; i < HB; i++) begin drive(1, 0, 1, 0, 0); drive(0, 1, 0, 0, 0); end
    for (int i = 0; i < HB; i++) begin drive(1, 0, 3, -2, 0); drive(0, 0, 7, 7, 0); end
    settle();
    chk("gap add beats", n_add - base, 16);
    chk_lanes("gap add R", 0, exp_add_r);
    chk_lanes("gap add Q", 1, exp_add_q);

    // Reset in the middle of CALC, then a fresh block.
    do_reset();
    for (int i = 0; i < HB; i++) drive(1, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) drive(1, 0, 3, -2, 0);
    do_reset();
    base = n_add;
    for (int i = 0; i < 2 * HB; i++) drive(1, 0, 0, 0, 1);
    settle();
    chk("fresh block add beats", n_add - base, 16);

    // Randomized traffic, partial flushes included.
    for (int i = 0; i < 1500; i++) begin
      int p;
      p = $urandom_range(0, 99);
      drive(p < 65, (p >= 55) && (p < 85), 0, 0, 1);
    end
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bfly_stage00.md
BFLY_STAGE00 -- requirements
Module: bfly_stage00

Interface
REQ-001 Parameter DATA_WIDTH, default 10: output sample width; input width is DATA_WIDTH-1.
REQ-002 Parameter NLANE, fixed 16: parallel lanes per cycle.
REQ-003 Parameter HALF_BLK, default 16: cycles per half-block (butterfly distance = HALF_BLK*NLANE samples).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 din_valid  input  1  input lanes valid this cycle.
REQ-007 flush  input  1  drain pending subtract results without new input.
REQ-008 din_R / din_Q  input  signed [DATA_WIDTH-2:0] x [0:15]  real/imag input lanes.
REQ-009 dout_valid  output  1  one output beat valid.
REQ-010 mux_sel  output  1  0 = add beat, 1 = sub beat; drives downstream add/sub select.
REQ-011 dout_R_add00 / dout_Q_add00  output  signed [DATA_WIDTH-1:0] x [0:15]  butterfly sum.
REQ-012 dout_R_sub00 / dout_Q_sub00  output  signed [DATA_WIDTH-1:0] x [0:15]  butterfly difference.
REQ-013 sub_pending  output  1  buffer holds un-emitted difference results.

Function
REQ-014 Two phases: FILL and CALC; 4-bit beat counter cnt (0..HALF_BLK-1) advances only on an accepted beat.
REQ-015 FILL, din_valid=1: lanes sign-extended to DATA_WIDTH, written to buffer[cnt]; at cnt=HALF_BLK-1, cnt->0, phase->CALC.
REQ-016 CALC, din_valid=1: add = buffer[cnt] + din, sub = buffer[cnt] - din per lane, full DATA_WIDTH precision, no overflow possible; add registered to dout_*_add00, sub written back to buffer[cnt].
REQ-017 CALC beat: dout_valid=1, mux_sel=0 next cycle (latency 1 cycle); at cnt=HALF_BLK-1, sub_pending->1, cnt->0, phase->FILL.
REQ-018 FILL beat with sub_pending=1: buffer[cnt] (old difference) registered to dout_*_sub00 before being overwritten by the new input; dout_valid=1, mux_sel=1 next cycle.
REQ-019 FILL, sub_pending=1, din_valid=0, flush=1: sub beat emitted as REQ-018, buffer not written, cnt advances; at cnt=HALF_BLK-1, sub_pending->0, cnt->0, phase stays FILL with nothing stored.
REQ-020 din_valid=1 and flush=1 together: din_valid wins, flush ignored.
REQ-021 flush in CALC or with sub_pending=0: ignored, no beat.
REQ-022 sub_pending clears at end of a FILL half-block regardless of whether beats came from input or flush; back-to-back blocks produce continuous beats add x16, sub x16 (sub overlapping next FILL).
REQ-023 Idle cycle (no accepted beat): dout_valid=0; all data outputs and mux_sel hold last value.
REQ-024 Non-selected output array holds its previous value on every beat.
REQ-025 A flush run that only partially drains leaves cnt mid-range; a later din_valid resumes FILL at that cnt, overwriting remaining differences after emitting them.

Reset
REQ-026 rstn=0 asynchronously: phase=FILL, cnt=0, sub_pending=0, dout_valid=0, mux_sel=0, all dout arrays 0.
REQ-027 Buffer contents need no reset; a reset mid-block discards the partial block and all pending differences.
REQ-028 First beat after rstn deassertion is accepted on the first rising edge with din_valid=1.

Configuration
REQ-029 Macro BFLY00_SCALE_EN defined: add and sub results arithmetically shifted right by 1 (floor) before registering/storing, sign-extended to DATA_WIDTH.
REQ-030 Macro BFLY00_SCALE_EN undefined: results unscaled, per REQ-016.

Verification
REQ-031 Reset, then 16 beats all lanes R=1,Q=0, then 16 beats R=3,Q=-2 -> 16 add beats R=4,Q=-2, mux_sel=0, each 1 cycle after input.
REQ-032 Continue with 16 FILL beats of zeros -> 16 sub beats R=-2,Q=2, mux_sel=1; sub_pending falls after 16th.
REQ-033 Block as REQ-031, then flush=1 for 20 cycles -> exactly 16 sub beats, dout_valid=0 thereafter.
REQ-034 Extremes R=+255 buffered, R=-256 in CALC -> add=-1, sub=511; with BFLY00_SCALE_EN add=-1, sub=255.
REQ-035 Gaps: din_valid toggled every other cycle -> outputs hold between beats, sequence identical to REQ-031.
REQ-036 rstn pulsed low at CALC beat 8 -> outputs 0 immediately; next 32 beats behave as fresh block.
